// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file and its control unit.
package reg_file_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NREGS = 8;

  typedef enum logic [1:0] {
    PAIR_NONE = 2'b00,
    PAIR_INC  = 2'b01,
    PAIR_DEC  = 2'b10,
    PAIR_RSVD = 2'b11
  } pair_op_e;

  // Pair-select width; kept at least one bit so a two-register file still has a port.
  function automatic int unsigned pair_sel_w(input int unsigned nregs);
    int unsigned aw;
    aw = $clog2(nregs);
    return (aw > 1) ? aw - 1 : 1;
  endfunction

endpackage

// File: rtl/reg_file_nx_if.sv
// Register-file port bundle: write port, two read ports and the pair pointer port.
interface reg_file_nx_if
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned PW = pair_sel_w(NREGS);

  logic               WR_EN;
  logic [AW-1:0]      WR_ADDR;
  logic [WIDTH-1:0]   WR_DATA;
  logic [AW-1:0]      RA_ADDR;
  logic [WIDTH-1:0]   RA_DATA;
  logic [AW-1:0]      RB_ADDR;
  logic [WIDTH-1:0]   RB_DATA;
  pair_op_e           PAIR_OP;
  logic [PW-1:0]      PAIR_SEL;
  logic [2*WIDTH-1:0] PAIR_DATA;
  logic               PAIR_WRAP;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, RA_ADDR, RB_ADDR, PAIR_OP, PAIR_SEL,
    input  RA_DATA, RB_DATA, PAIR_DATA, PAIR_WRAP
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, RA_ADDR, RB_ADDR, PAIR_OP, PAIR_SEL,
    output RA_DATA, RB_DATA, PAIR_DATA, PAIR_WRAP
  );

endinterface

// File: rtl/pair_incdec.sv
// Combinational +/-1 on a register pair; wrap flags an increment from all-ones or a decrement from zero.
module pair_incdec
  import reg_file_pkg::*;
#(
  parameter int unsigned W2 = 2 * DEF_WIDTH
) (
  input  logic [W2-1:0] i_operand,
  input  pair_op_e      i_op,
  output logic [W2-1:0] o_result,
  output logic          o_wrap
);

  always_comb begin
    o_result = i_operand;
    o_wrap   = 1'b0;
    case (i_op)
      PAIR_INC: begin
        o_result = i_operand + W2'(1);
        o_wrap   = &i_operand;
      end
      PAIR_DEC: begin
        o_result = i_operand - W2'(1);
        o_wrap   = ~|i_operand;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file_nx.sv
// Parametrised register file: two combinational read ports, one write port, pair inc/dec.
// Optional write-through on the A/B read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_nx
  import reg_file_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      NREGS     = DEF_NREGS,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_nx_if.slave bus
);

  localparam int unsigned AW     = $clog2(NREGS);
  localparam int unsigned NPAIRS = NREGS / 2;

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic               r_pair_wrap;

  logic [WIDTH-1:0]   w_ra_data;
  logic [WIDTH-1:0]   w_rb_data;
  logic               w_wr_ok;
  logic               w_pair_ok;
  logic [AW-1:0]      w_lo_idx;
  logic [AW-1:0]      w_hi_idx;
  logic [2*WIDTH-1:0] w_pair_data;
  logic [2*WIDTH-1:0] w_pair_next;
  logic               w_wrap;
  logic               w_collide;
  logic               w_op_exec;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  assign w_wr_ok   = bus.WR_EN && in_range(bus.WR_ADDR);
  assign w_pair_ok = 32'(bus.PAIR_SEL) < NPAIRS;
  assign w_lo_idx  = AW'({bus.PAIR_SEL, 1'b0});
  assign w_hi_idx  = w_lo_idx | AW'(1);

  // Read muxes; out-of-range indices read zero.
  always_comb begin
    w_ra_data = '0;
    w_rb_data = '0;
    if (in_range(bus.RA_ADDR)) w_ra_data = r_regs[bus.RA_ADDR];
    if (in_range(bus.RB_ADDR)) w_rb_data = r_regs[bus.RB_ADDR];
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_ok && (bus.WR_ADDR == bus.RA_ADDR)) w_ra_data = bus.WR_DATA;
    if (w_wr_ok && (bus.WR_ADDR == bus.RB_ADDR)) w_rb_data = bus.WR_DATA;
`endif
  end

  always_comb begin
    w_pair_data = '0;
    if (w_pair_ok) w_pair_data = {r_regs[w_hi_idx], r_regs[w_lo_idx]};
  end

  // A write landing in either half of the selected pair cancels the pair op.
  assign w_collide = w_wr_ok && ((bus.WR_ADDR | AW'(1)) == w_hi_idx);
  assign w_op_exec = w_pair_ok && !w_collide &&
                     ((bus.PAIR_OP == PAIR_INC) || (bus.PAIR_OP == PAIR_DEC));

  pair_incdec #(
    .W2 (2 * WIDTH)
  ) u_pair_incdec (
    .i_operand (w_pair_data),
    .i_op      (bus.PAIR_OP),
    .o_result  (w_pair_next),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
      r_pair_wrap <= 1'b0;
    end else begin
      if (w_wr_ok) r_regs[bus.WR_ADDR] <= bus.WR_DATA;
      if (w_op_exec) begin
        r_regs[w_hi_idx] <= w_pair_next[2*WIDTH-1:WIDTH];
        r_regs[w_lo_idx] <= w_pair_next[WIDTH-1:0];
      end
      r_pair_wrap <= w_op_exec && w_wrap;
    end
  end

  assign bus.RA_DATA   = w_ra_data;
  assign bus.RB_DATA   = w_rb_data;
  assign bus.PAIR_DATA = w_pair_data;
  assign bus.PAIR_WRAP = r_pair_wrap;

endmodule
